// File: rtl/pea_pkg.sv
// Shared definitions for the Polynomial Evaluation Accelerator (PEA):
// default sizes, FSM state encoding and address-width helpers.
package pea_pkg;

    localparam int PEA_WORD_SIZE   = 16;
    localparam int PEA_NUM_VECTORS = 8;
    localparam int PEA_MAX_DEGREE  = 10;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        REQ  = ST_REQ_ENC,
        WAIT = ST_WAIT_ENC,
        DONE = ST_DONE_ENC
    } pea_state_e;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    // Vector address width; at least one bit so the port never collapses.
    function automatic int vec_aw(input int n_vectors);
        return (n_vectors > 1) ? log2(n_vectors) : 1;
    endfunction

    // Coefficient/degree width; the extra bit lets illegal degrees be seen.
    function automatic int coef_aw(input int max_deg);
        return log2(max_deg) + 1;
    endfunction

endpackage

// File: rtl/horner_mac.sv
// One Horner step: acc*x + coef, unsigned.
// Build option PEA_SAT_ARITH_EN: saturate to all-ones instead of wrapping.
module horner_mac #(
    parameter int word_size = 16
) (
    input  logic [word_size-1:0] acc,
    input  logic [word_size-1:0] x,
    input  logic [word_size-1:0] coef,
    output logic [word_size-1:0] mac_out
);

    localparam int PW = 2 * word_size;

    logic [PW-1:0] prod;
    logic [PW:0]   sum;

    // Full-width product plus coefficient, then truncate or clamp.
    always_comb begin
        prod = PW'(acc) * PW'(x);
        sum  = (PW+1)'(prod) + (PW+1)'(coef);
`ifdef PEA_SAT_ARITH_EN
        if (|sum[PW:word_size]) mac_out = '1;
        else                    mac_out = sum[word_size-1:0];
`else
        mac_out = sum[word_size-1:0];
`endif
    end

endmodule

// File: rtl/horner_eval_engine.sv
// Horner-rule polynomial evaluator reading coefficients from the S RAM,
// highest index first. Build option PEA_SAT_ARITH_EN selects saturating MAC.
//
// state | meaning
// IDLE  | ready for a command; latches vec/degree/x on start
// REQ   | one-cycle RAM read request for S[vec][idx]
// WAIT  | waiting for q_en; folds q into acc, then next index or finish
// DONE  | publishes result (or error) for one cycle
module horner_eval_engine
    import pea_pkg::*;
#(
    parameter int word_size   = PEA_WORD_SIZE,
    parameter int num_vectors = PEA_NUM_VECTORS,
    parameter int max_degree  = PEA_MAX_DEGREE,
    localparam int VW = vec_aw(num_vectors),
    localparam int CW = coef_aw(max_degree)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VW-1:0]        vec_sel,
    input  logic [CW-1:0]        degree,
    input  logic [word_size-1:0] x_val,
    output logic                 ready,
    output logic [VW-1:0]        rd_vector_addr,
    output logic [CW-1:0]        rd_coef_addr,
    output logic                 re_en,
    input  logic [word_size-1:0] q,
    input  logic                 q_en,
    output logic [word_size-1:0] result,
    output logic                 result_valid,
    output logic                 cmd_err
);

    pea_state_e           state_q, state_d;
    logic [VW-1:0]        vec_q;
    logic [CW-1:0]        idx_q;
    logic [word_size-1:0] x_q;
    logic [word_size-1:0] acc_q;
    logic                 err_q;
    logic [word_size-1:0] mac_out;
    logic                 illegal_deg;

    assign illegal_deg    = (degree > CW'(max_degree));
    assign rd_vector_addr = vec_q;
    assign rd_coef_addr   = idx_q;

    horner_mac #(.word_size(word_size)) u_mac (
        .acc     (acc_q),
        .x       (x_q),
        .coef    (q),
        .mac_out (mac_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        re_en   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = illegal_deg ? DONE : REQ;
            end
            REQ: begin
                re_en   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (q_en) state_d = (idx_q == '0) ? DONE : REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, accumulator, index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            idx_q        <= '0;
            x_q          <= '0;
            acc_q        <= '0;
            err_q        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            cmd_err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q <= vec_sel;
                        idx_q <= degree;
                        x_q   <= x_val;
                        acc_q <= '0;
                        err_q <= illegal_deg;
                    end
                end
                WAIT: begin
                    if (q_en) begin
                        acc_q <= mac_out;
                        if (idx_q != '0) idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    result_valid <= 1'b1;
                    cmd_err      <= err_q;
                    result       <= err_q ? '0 : acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_horner_eval_engine.sv
// Directed self-checking bench for horner_eval_engine with a 1-cycle RAM model.
module tb_horner_eval_engine;
    import pea_pkg::*;

    localparam int W  = PEA_WORD_SIZE;
    localparam int VW = vec_aw(PEA_NUM_VECTORS);
    localparam int CW = coef_aw(PEA_MAX_DEGREE);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] vec_sel;
    logic [CW-1:0] degree;
    logic [W-1:0]  x_val;
    logic          ready;
    logic [VW-1:0] rd_vector_addr;
    logic [CW-1:0] rd_coef_addr;
    logic          re_en;
    logic [W-1:0]  q;
    logic          q_en;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          cmd_err;

    logic [W-1:0]  mem [0:(1<<VW)-1][0:(1<<CW)-1];
    logic [W-1:0]  ram_q = '0;
    logic          ram_qen = 1'b0;
    logic          qen_force = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int accept_cyc = 0;
    int lat = 0;
    int rv_seen = 0;
    int re_addr [$];
    int re_vec  [$];

    horner_eval_engine dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .vec_sel        (vec_sel),
        .degree         (degree),
        .x_val          (x_val),
        .ready          (ready),
        .rd_vector_addr (rd_vector_addr),
        .rd_coef_addr   (rd_coef_addr),
        .re_en          (re_en),
        .q              (q),
        .q_en           (q_en),
        .result         (result),
        .result_valid   (result_valid),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid the cycle after the read request.
    always @(posedge clk) begin
        ram_qen <= re_en;
        if (re_en) ram_q <= mem[rd_vector_addr][rd_coef_addr];
    end

    assign q_en = ram_qen | qen_force;
    assign q    = ram_qen ? ram_q : 16'h7777;

    // Read-request monitor.
    always @(posedge clk) begin
        if (re_en) begin
            re_addr.push_back(int'(rd_coef_addr));
            re_vec.push_back(int'(rd_vector_addr));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int v, input int d, input logic [W-1:0] x);
        check("ready_before_start", {31'd0, ready}, 32'd1);
        re_addr.delete();
        re_vec.delete();
        start   = 1'b1;
        vec_sel = VW'(v);
        degree  = CW'(d);
        x_val   = x;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        vec_sel = ~vec_sel;
        degree  = '0;
        x_val   = ~x;
        accept_cyc = cyc;
    endtask

    task automatic wait_result();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid) begin
                found = 1'b1;
                break;
            end
        end
        lat = cyc - accept_cyc;
        check("result_valid_seen", {31'd0, result_valid}, 32'd1);
    endtask

    initial begin
        for (int v = 0; v < (1 << VW); v++)
            for (int c = 0; c < (1 << CW); c++)
                mem[v][c] = 16'hDEAD;
        mem[2][0] = 16'd3; mem[2][1] = 16'd2; mem[2][2] = 16'd1;
        mem[0][0] = 16'd7;
        mem[1][0] = 16'hFFFF; mem[1][1] = 16'hFFFF; mem[1][2] = 16'hFFFF;
        mem[3][0] = 16'd1; mem[3][1] = 16'd0; mem[3][2] = 16'd2; mem[3][3] = 16'd1;
        for (int c = 0; c < 6; c++) mem[4][c] = 16'(c + 1);

        rst = 1'b1; start = 1'b0; vec_sel = '0; degree = '0; x_val = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",    {31'd0, ready},        32'd1);
        check("rst_re_en",    {31'd0, re_en},        32'd0);
        check("rst_valid",    {31'd0, result_valid}, 32'd0);
        check("rst_cmd_err",  {31'd0, cmd_err},      32'd0);
        check("rst_result",   {16'd0, result},       32'd0);
        check("rst_vec_addr", 32'(rd_vector_addr),   32'd0);
        check("rst_coef_addr",32'(rd_coef_addr),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // p(x)=1*x^2+2*x+3 at x=5 -> 38
        issue(2, 2, 16'd5);
        wait_result();
        check("t1_result",  {16'd0, result},  32'd38);
        check("t1_latency", 32'(lat),         32'd7);
        check("t1_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("t1_re_count",32'(re_addr.size()), 32'd3);
        if (re_addr.size() == 3) begin
            check("t1_addr0", 32'(re_addr[0]), 32'd2);
            check("t1_addr1", 32'(re_addr[1]), 32'd1);
            check("t1_addr2", 32'(re_addr[2]), 32'd0);
            check("t1_vec",   32'(re_vec[2]),  32'd2);
        end

        // Back-to-back: start in the IDLE cycle right after DONE.
        issue(0, 0, 16'h1234);
        wait_result();
        check("t2_result",  {16'd0, result}, 32'd7);
        check("t2_latency", 32'(lat),        32'd3);
        check("t2_re_count",32'(re_addr.size()), 32'd1);
        if (re_addr.size() == 1) check("t2_addr0", 32'(re_addr[0]), 32'd0);
        @(negedge clk);
        check("t2_result_held", {16'd0, result}, 32'd7);
        check("t2_valid_pulse", {31'd0, result_valid}, 32'd0);

        // Wrap vs saturate.
        issue(1, 2, 16'h0100);
        wait_result();
`ifdef PEA_SAT_ARITH_EN
        check("t3_result_sat",  {16'd0, result}, 32'h0000FFFF);
`else
        check("t3_result_wrap", {16'd0, result}, 32'h0000FEFF);
`endif
        check("t3_latency", 32'(lat), 32'd7);

        // Illegal degree.
        @(negedge clk);
        issue(2, 11, 16'd5);
        wait_result();
        check("t4_latency", 32'(lat),         32'd1);
        check("t4_cmd_err", {31'd0, cmd_err}, 32'd1);
        check("t4_result",  {16'd0, result},  32'd0);
        check("t4_re_count",32'(re_addr.size()), 32'd0);

        // Second start during a busy evaluation is ignored.
        @(negedge clk);
        issue(3, 3, 16'd3);
        @(negedge clk);
        check("t5_ready_busy0", {31'd0, ready}, 32'd0);
        start = 1'b1; vec_sel = VW'(0); degree = CW'(0); x_val = 16'd9;
        @(negedge clk);
        check("t5_ready_busy1", {31'd0, ready}, 32'd0);
        start = 1'b0;
        wait_result();
        check("t5_result",  {16'd0, result}, 32'd46);
        check("t5_latency", 32'(lat),        32'd9);
        check("t5_re_count",32'(re_addr.size()), 32'd4);
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        check("t5_no_second_result", 32'(rv_seen), 32'd0);

        // Reset while WAITing on a degree-5 read.
        issue(4, 5, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_ready_after_rst", {31'd0, ready},        32'd1);
        check("t6_no_valid",        {31'd0, result_valid}, 32'd0);
        rv_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        check("t6_no_result_after_abort", 32'(rv_seen), 32'd0);
        check("t6_re_count", 32'(re_addr.size()), 32'd1);

        // New command after abort, with a stray q_en during REQ: 4*2+5 = 13.
        mem[4][0] = 16'd5; mem[4][1] = 16'd4;
        issue(4, 1, 16'd2);
        qen_force = 1'b1;
        @(negedge clk);
        qen_force = 1'b0;
        wait_result();
        check("t7_result",  {16'd0, result}, 32'd13);
        check("t7_latency", 32'(lat),        32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
